// File: rtl/trace_trigger_gate.sv
// Trace gate between the core pc/instr taps and the trace stream.
// The gate combines these functions:
//   - address-window filtering
//   - a start/end/WFI trigger FSM with re-arm
//   - a saturating cycle-delta stamp
//   - a one-entry valid/ready output register
//   - a saturating drop counter
//
// state   | meaning
// IDLE    | disabled or just enabled; picks ARMED/TRACING from start_en
// ARMED   | waiting for a candidate at start_addr
// TRACING | emitting in-range candidates
// STOPPED | run ended (end_addr or WFI stall); waits for REARM
module trace_trigger_gate #(
  parameter int                     XLEN                                = 64,
  parameter int                     INSTR_WIDTH                         = 32,
  parameter int                     NUM_RANGES                          = 4,
  parameter int                     DELTA_WIDTH                         = 32,
  parameter int                     WFI_STOP_THRESHOLD                  = 255,
  parameter logic [INSTR_WIDTH-1:0] WFI_INSTRUCTION                     = 32'h10500073,
  parameter int                     CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1,
  parameter int                     CTRL_ADDR_WIDTH                     = 8,
  parameter int                     CTRL_DATA_WIDTH                     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [INSTR_WIDTH-1:0]     instr_i,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_i,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata_i,
  input  logic                       ctrl_write_enable_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [INSTR_WIDTH-1:0]     out_instr_o,
  output logic [DELTA_WIDTH-1:0]     out_clk_delta_o,
  output logic                       out_last_o,
  output logic [1:0]                 state_o,
  output logic [31:0]                dropped_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRACING = 2'd2, STOPPED = 2'd3} state_e;

  localparam logic [7:0] WFI_THR = 8'(WFI_STOP_THRESHOLD);
  localparam logic [7:0] WFI_PRE = 8'(WFI_STOP_THRESHOLD - 1);

  state_e                   state_q, state_d;
  logic [XLEN-1:0]          pc_s0_q, pc_s1_q;
  logic [INSTR_WIDTH-1:0]   instr_s0_q, instr_s1_q;
  logic                     we_q;
  logic                     start_en_q, end_en_q;
  logic [XLEN-1:0]          start_addr_q, end_addr_q;
  logic [NUM_RANGES-1:0]    range_en_q;
  logic [XLEN-1:0]          lo_q [NUM_RANGES];
  logic [XLEN-1:0]          hi_q [NUM_RANGES];
  logic [7:0]               wfi_cnt_q;
  logic [DELTA_WIDTH-1:0]   delta_cnt_q;
  logic [31:0]              dropped_q;
  logic                     out_valid_q, out_last_q;
  logic [XLEN-1:0]          out_pc_q;
  logic [INSTR_WIDTH-1:0]   out_instr_q;
  logic [DELTA_WIDTH-1:0]   out_delta_q;

  logic wr_fire, rearm, is_wfi, wfi_stop, cand, in_range, win_hit;
  logic emit, emit_last, load, drop;

  assign wr_fire  = (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ? (ctrl_write_enable_i & ~we_q)
                                                               : ctrl_write_enable_i;
  assign rearm    = wr_fire && (ctrl_addr_i == CTRL_ADDR_WIDTH'(5));
  assign is_wfi   = (instr_s1_q == WFI_INSTRUCTION);
  assign wfi_stop = en_i && is_wfi && (wfi_cnt_q == WFI_PRE);
  assign cand     = ((pc_s1_q != pc_s0_q) && (pc_s1_q != '0)) || (wfi_cnt_q == WFI_PRE);
  assign load     = emit && (!out_valid_q || out_ready_i);
  assign drop     = emit && out_valid_q && !out_ready_i;

  // Window match: any enabled window containing pc_s1; no enabled windows passes all
  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (range_en_q[i] && (lo_q[i] <= pc_s1_q) && (pc_s1_q <= hi_q[i])) win_hit = 1'b1;
    end
    in_range = (range_en_q == '0) || win_hit;
  end

  // Trigger FSM next state and emit decision (uses pre-write config values)
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = start_en_q ? ARMED : TRACING;
        ARMED: begin
          if (cand && (pc_s1_q == start_addr_q)) begin
            state_d = TRACING;
            emit    = in_range;
          end
        end
        TRACING: begin
          if (cand && end_en_q && (pc_s1_q == end_addr_q)) begin
            state_d   = STOPPED;
            emit      = in_range;
            emit_last = 1'b1;
          end else if (wfi_stop) begin
            state_d   = STOPPED;
            emit      = cand && in_range;
            emit_last = 1'b1;
          end else begin
            emit = cand && in_range;
          end
        end
        STOPPED: if (rearm) state_d = start_en_q ? ARMED : TRACING;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, tap pipeline and WFI stall counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pc_s0_q    <= '0;
      pc_s1_q    <= '0;
      instr_s0_q <= '0;
      instr_s1_q <= '0;
      wfi_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_s0_q    <= pc_i;
      pc_s1_q    <= pc_s0_q;
      instr_s0_q <= instr_i;
      instr_s1_q <= instr_s0_q;
      if (rearm || !is_wfi)                 wfi_cnt_q <= '0;
      else if (en_i && wfi_cnt_q != WFI_THR) wfi_cnt_q <= wfi_cnt_q + 8'd1;
    end
  end

  // Config register file, write-only
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q         <= 1'b0;
      start_en_q   <= 1'b0;
      end_en_q     <= 1'b0;
      start_addr_q <= '0;
      end_addr_q   <= '1;
      range_en_q   <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '1;
      end
    end else begin
      we_q <= ctrl_write_enable_i;
      if (wr_fire) begin
        case (ctrl_addr_i)
          CTRL_ADDR_WIDTH'(0): start_en_q   <= ctrl_wdata_i[0];
          CTRL_ADDR_WIDTH'(1): end_en_q     <= ctrl_wdata_i[0];
          CTRL_ADDR_WIDTH'(2): start_addr_q <= XLEN'(ctrl_wdata_i);
          CTRL_ADDR_WIDTH'(3): end_addr_q   <= XLEN'(ctrl_wdata_i);
          CTRL_ADDR_WIDTH'(4): range_en_q   <= ctrl_wdata_i[NUM_RANGES-1:0];
          default: ;
        endcase
        for (int i = 0; i < NUM_RANGES; i++) begin
          if (ctrl_addr_i == CTRL_ADDR_WIDTH'(16 + 2*i)) lo_q[i] <= XLEN'(ctrl_wdata_i);
          if (ctrl_addr_i == CTRL_ADDR_WIDTH'(17 + 2*i)) hi_q[i] <= XLEN'(ctrl_wdata_i);
        end
      end
    end
  end

  // Output register, delta stamp and drop counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_delta_q <= '0;
      delta_cnt_q <= '0;
      dropped_q   <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_last_q  <= emit_last;
        out_pc_q    <= pc_s1_q;
        out_instr_q <= instr_s1_q;
        out_delta_q <= delta_cnt_q;
        delta_cnt_q <= DELTA_WIDTH'(1);
      end else begin
        if (out_ready_i) out_valid_q <= 1'b0;
        if (delta_cnt_q != '1) delta_cnt_q <= delta_cnt_q + DELTA_WIDTH'(1);
      end
      if (wr_fire && ctrl_addr_i == CTRL_ADDR_WIDTH'(6)) dropped_q <= '0;
      else if (drop && dropped_q != '1)                  dropped_q <= dropped_q + 32'd1;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_last_o      = out_last_q;
  assign out_pc_o        = out_pc_q;
  assign out_instr_o     = out_instr_q;
  assign out_clk_delta_o = out_delta_q;
  assign state_o         = state_q;
  assign dropped_count_o = dropped_q;

endmodule

// File: tb/tb_trace_trigger_gate.sv
// Directed bench for trace_trigger_gate: triggers, windows, backpressure, WFI stop, reset.
module tb_trace_trigger_gate;
  localparam logic [31:0] WFI = 32'h10500073;

  logic        clk = 1'b0;
  logic        rst_n, en, we, out_ready;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        out_valid, out_last;
  logic [63:0] out_pc;
  logic [31:0] out_instr, out_clk_delta, dropped_count;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  logic [63:0] mon_pc[$];
  logic [31:0] mon_instr[$];
  logic [31:0] mon_delta[$];
  logic        mon_last[$];

  trace_trigger_gate dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pc_i(pc), .instr_i(instr),
    .ctrl_addr_i(ctrl_addr), .ctrl_wdata_i(ctrl_wdata), .ctrl_write_enable_i(we),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_instr_o(out_instr), .out_clk_delta_o(out_clk_delta), .out_last_o(out_last),
    .state_o(state), .dropped_count_o(dropped_count)
  );

  always #5 clk = ~clk;

  // Record every completed handshake
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_pc.push_back(out_pc);
      mon_instr.push_back(out_instr);
      mon_delta.push_back(out_clk_delta);
      mon_last.push_back(out_last);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    ctrl_addr  = a;
    ctrl_wdata = d;
    we = 1'b1;
    tick();
    we = 1'b0;
    tick();
  endtask

  task automatic drive(input logic [63:0] p, input int n);
    pc    = p;
    instr = 32'h13 + p[31:0];
    tick(n);
  endtask

  task automatic clr();
    mon_pc.delete();
    mon_instr.delete();
    mon_delta.delete();
    mon_last.delete();
  endtask

  function automatic logic [63:0] qpc(input int i);
    return (mon_pc.size() > i) ? mon_pc[i] : 64'hDEAD;
  endfunction

  function automatic logic [31:0] qdelta(input int i);
    return (mon_delta.size() > i) ? mon_delta[i] : 32'hDEAD;
  endfunction

  function automatic logic qlast(input int i);
    return (mon_last.size() > i) ? mon_last[i] : 1'bx;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 1'b0; out_ready = 1'b1;
    pc = '0; instr = 32'h13; ctrl_addr = '0; ctrl_wdata = '0;
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_dropped", dropped_count, 0);
    chk("rst_delta", out_clk_delta, 0);
    rst_n = 1'b1;

    // 1: free trace, no triggers or windows
    en = 1'b1;
    tick(2);
    chk("t1_state", state, 2);
    drive(64'h100, 2); drive(64'h104, 2); drive(64'h108, 2); drive(64'h0, 4);
    chk("t1_count", mon_pc.size(), 3);
    chk("t1_pc0", qpc(0), 64'h100);
    chk("t1_pc1", qpc(1), 64'h104);
    chk("t1_pc2", qpc(2), 64'h108);
    chk("t1_instr1", (mon_instr.size() > 1) ? mon_instr[1] : 32'hDEAD, 32'h13 + 32'h104);
    chk("t1_delta1", qdelta(1), 2);
    chk("t1_delta2", qdelta(2), 2);
    chk("t1_last2", qlast(2), 0);

    // 2: start trigger
    clr();
    wr(8'h00, 64'h1);
    chk("t2_still_tracing", state, 2);
    en = 1'b0;
    tick();
    chk("t2_idle", state, 0);
    en = 1'b1;
    tick();
    chk("t2_armed", state, 1);
    wr(8'h02, 64'h200);
    drive(64'h100, 2);
    chk("t2_armed_hold", state, 1);
    drive(64'h200, 2); drive(64'h204, 2); drive(64'h0, 4);
    chk("t2_tracing", state, 2);
    chk("t2_count", mon_pc.size(), 2);
    chk("t2_pc0", qpc(0), 64'h200);
    chk("t2_pc1", qpc(1), 64'h204);

    // 3: end trigger and re-arm
    clr();
    wr(8'h01, 64'h1);
    wr(8'h03, 64'h300);
    wr(8'h00, 64'h0);
    drive(64'h2F0, 2); drive(64'h300, 2); drive(64'h304, 2); drive(64'h0, 4);
    chk("t3_count", mon_pc.size(), 2);
    chk("t3_pc0", qpc(0), 64'h2F0);
    chk("t3_last0", qlast(0), 0);
    chk("t3_pc1", qpc(1), 64'h300);
    chk("t3_last1", qlast(1), 1);
    chk("t3_stopped", state, 3);
    wr(8'h05, 64'h0);
    chk("t3_rearm", state, 2);
    wr(8'h01, 64'h0);

    // 4: address windows
    clr();
    wr(8'h10, 64'h1000); wr(8'h11, 64'h1FFF);
    wr(8'h12, 64'h3000); wr(8'h13, 64'h3000);
    wr(8'h04, 64'h3);
    drive(64'h0FFC, 2); drive(64'h1000, 2); drive(64'h2000, 2); drive(64'h3000, 2); drive(64'h0, 4);
    chk("t4_count", mon_pc.size(), 2);
    chk("t4_pc0", qpc(0), 64'h1000);
    chk("t4_pc1", qpc(1), 64'h3000);
    wr(8'h04, 64'h0);

    // 5: backpressure drops
    clr();
    out_ready = 1'b0;
    drive(64'h500, 2); drive(64'h504, 2);
    chk("t5_valid", out_valid, 1);
    chk("t5_pc_first", out_pc, 64'h500);
    drive(64'h508, 2); drive(64'h50C, 2); drive(64'h510, 2); drive(64'h0, 4);
    chk("t5_dropped", dropped_count, 4);
    chk("t5_pc_stable", out_pc, 64'h500);
    chk("t5_valid_held", out_valid, 1);
    chk("t5_no_xfer", mon_pc.size(), 0);
    out_ready = 1'b1;
    tick(2);
    chk("t5_xfer_count", mon_pc.size(), 1);
    chk("t5_xfer_pc", qpc(0), 64'h500);
    chk("t5_valid_clr", out_valid, 0);
    wr(8'h06, 64'h0);
    chk("t5_drop_clear", dropped_count, 0);

    // 6: WFI stall auto-stop, then async reset with a packet pending
    pc = 64'h600;
    instr = WFI;
    tick(256);
    chk("t6_pre_state", state, 2);
    chk("t6_pre_valid", out_valid, 0);
    tick();
    chk("t6_stopped", state, 3);
    chk("t6_valid", out_valid, 1);
    chk("t6_last", out_last, 1);
    chk("t6_pc", out_pc, 64'h600);
    chk("t6_instr", out_instr, WFI);
    out_ready = 1'b0;
    tick(3);
    chk("t6_valid_hold", out_valid, 1);
    chk("t6_no_drop", dropped_count, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pc", out_pc, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_delta", out_clk_delta, 0);
    chk("t6_rst_instr", out_instr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
